// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: default frame geometry,
// receive FSM state encoding and a small 2-of-3 majority helper.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// ---------------------------------------------------------------------------
// uart_bit_sampler
// Oversampling tick counter plus 3-sample majority voter for one bit period.
//
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   run          - counter runs while high; held at 0 while low
//   sample_tick  - oversampling enable
//   rx_in        - synchronised serial line
//   tick_wrap    - pulse on the tick that ends the bit period
//   vote_tick    - pulse on the last of the three vote ticks
//   bit_val      - majority of the three vote samples (valid with vote_tick)
// ---------------------------------------------------------------------------
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic sample_tick,
    input  logic rx_in,
    output logic tick_wrap,
    output logic vote_tick,
    output logic bit_val
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] VOTE_0    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] VOTE_1    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] VOTE_2    = CW'(OVERSAMPLE / 2 + 1);

    logic [CW-1:0] tick_cnt;
    logic          samp0;
    logic          samp1;

    // Counter is held at zero whenever the receiver is idle, so the first
    // bit period after a start is aligned to the start_det edge.
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            tick_cnt <= '0;
        end else if (sample_tick) begin
            tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
        end
    end

    // The first two vote samples are stored; the third is taken live so the
    // vote result is usable on the same clk as the final vote tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp0 <= 1'b0;
            samp1 <= 1'b0;
        end else if (sample_tick) begin
            if (tick_cnt == VOTE_0) samp0 <= rx_in;
            if (tick_cnt == VOTE_1) samp1 <= rx_in;
        end
    end

    assign tick_wrap = run && sample_tick && (tick_cnt == LAST_TICK);
    assign vote_tick = run && sample_tick && (tick_cnt == VOTE_2);
    assign bit_val   = majority3(samp0, samp1, rx_in);

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// UART receive controller: collects data (and optional parity) bits after a
// qualified start bit, checks the stop bit, and presents completed words
// through a valid/ready holding register.
//
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   sample_tick  - oversampling enable, OVERSAMPLE pulses per bit
//   rx_in        - synchronised serial line, idle high
//   start_det    - one-clk pulse at the end of a qualified start bit
//   rx_ready     - consumer accepts rx_data
//   rx_data      - received word (LSB first on the line)
//   rx_valid     - rx_data holds an unread word
//   frame_err    - one-clk pulse, stop bit voted 0
//   parity_err   - one-clk pulse, parity mismatch
//   overrun      - one-clk pulse, completed word lost
//   busy         - receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    input  logic                 start_det,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    rx_state_t            state;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bad;

    logic run;
    logic tick_wrap;
    logic vote_tick;
    logic bit_val;
    logic word_done;

    assign run  = (state != IDLE);
    assign busy = run;

    uart_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .sample_tick (sample_tick),
        .rx_in       (rx_in),
        .tick_wrap   (tick_wrap),
        .vote_tick   (vote_tick),
        .bit_val     (bit_val)
    );

    // A word is good only if the stop bit votes 1 and parity (when used)
    // matched; this is evaluated on the stop bit's vote tick.
    assign word_done = (state == STOP) && vote_tick && bit_val && !parity_bad;

    // Receive FSM. The stop bit is judged at its vote tick and the FSM returns
    // to IDLE immediately, leaving the second half of the stop bit free for
    // the next start bit to be qualified.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bad <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state      <= DATA;
                        bit_idx    <= '0;
                        parity_bad <= 1'b0;
                    end
                end
                DATA: begin
                    if (vote_tick) begin
                        shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                    end
                    if (tick_wrap) begin
                        if (bit_idx == LAST_BIT) begin
                            state <= PARITY_EN ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (vote_tick) begin
                        parity_bad <= bit_val != ((^shift_reg) ^ PARITY_ODD);
                    end
                    if (tick_wrap) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (vote_tick) begin
                        frame_err  <= !bit_val;
                        parity_err <= parity_bad;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register and handshake. A completing word may replace an
    // unread one only when the consumer takes the old one in the same clk;
    // otherwise the new word is dropped and overrun is flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl. Two instances: index 0 without
// parity, index 1 with even parity. A transaction-level model tracks the
// holding register, busy and the error pulses per clk.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int OS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            sample_tick;
    logic [1:0]      rx_in;
    logic [1:0]      start_det;
    logic [1:0]      rx_ready;
    logic [1:0][7:0] rx_data;
    logic [1:0]      rx_valid;
    logic [1:0]      frame_err;
    logic [1:0]      parity_err;
    logic [1:0]      overrun;
    logic [1:0]      busy;

    uart_rx_ctrl #(
        .DATA_BITS (8), .OVERSAMPLE (OS), .PARITY_EN (1'b0), .PARITY_ODD (1'b0)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .sample_tick (sample_tick),
        .rx_in (rx_in[0]), .start_det (start_det[0]), .rx_ready (rx_ready[0]),
        .rx_data (rx_data[0]), .rx_valid (rx_valid[0]), .frame_err (frame_err[0]),
        .parity_err (parity_err[0]), .overrun (overrun[0]), .busy (busy[0])
    );

    uart_rx_ctrl #(
        .DATA_BITS (8), .OVERSAMPLE (OS), .PARITY_EN (1'b1), .PARITY_ODD (1'b0)
    ) u_dut_par (
        .clk (clk), .rst_n (rst_n), .sample_tick (sample_tick),
        .rx_in (rx_in[1]), .start_det (start_det[1]), .rx_ready (rx_ready[1]),
        .rx_data (rx_data[1]), .rx_valid (rx_valid[1]), .frame_err (frame_err[1]),
        .parity_err (parity_err[1]), .overrun (overrun[1]), .busy (busy[1])
    );

    int vectors = 0;
    int miscompares = 0;

    bit       m_valid [2];
    logic [7:0] m_data [2];
    bit       m_busy  [2];
    bit       ev_start [2];
    bit       ev_done  [2];
    bit       ev_ferr  [2];
    bit       ev_perr  [2];
    logic [7:0] ev_word [2];
    int       fe_cnt [2];
    int       pe_cnt [2];
    int       ov_cnt [2];
    int       cyc = 0;
    int       start_cyc = 0;
    int       rise_cyc = -1;
    bit       busy_at_rise = 1'b1;
    bit       prev_valid0 = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit even_parity_bit(input logic [7:0] w);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(w[i]);
        return (ones % 2) == 1;
    endfunction

    // One clock: advance the model with the events the stimulus announced for
    // this edge, then compare every output on the falling edge.
    task automatic step();
        bit ef [2];
        bit ep [2];
        bit eo [2];
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            ef[d] = 1'b0; ep[d] = 1'b0; eo[d] = 1'b0;
            if (!rst_n) begin
                m_valid[d] = 1'b0; m_data[d] = 8'h00; m_busy[d] = 1'b0;
            end else if (ev_done[d]) begin
                m_busy[d] = 1'b0;
                ef[d] = ev_ferr[d];
                ep[d] = ev_perr[d];
                if (!ev_ferr[d] && !ev_perr[d]) begin
                    if (!m_valid[d] || rx_ready[d]) begin
                        m_data[d]  = ev_word[d];
                        m_valid[d] = 1'b1;
                    end else begin
                        eo[d] = 1'b1;
                    end
                end else if (m_valid[d] && rx_ready[d]) begin
                    m_valid[d] = 1'b0;
                end
            end else begin
                if (m_valid[d] && rx_ready[d]) m_valid[d] = 1'b0;
                if (ev_start[d] && !m_busy[d]) m_busy[d] = 1'b1;
            end
            ev_done[d]  = 1'b0;
            ev_start[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rx_valid%0d", d), 32'(rx_valid[d]), 32'(m_valid[d]));
            checkOutput($sformatf("rx_data%0d", d), 32'(rx_data[d]), 32'(m_data[d]));
            checkOutput($sformatf("busy%0d", d), 32'(busy[d]), 32'(m_busy[d]));
            checkOutput($sformatf("frame_err%0d", d), 32'(frame_err[d]), 32'(ef[d]));
            checkOutput($sformatf("parity_err%0d", d), 32'(parity_err[d]), 32'(ep[d]));
            checkOutput($sformatf("overrun%0d", d), 32'(overrun[d]), 32'(eo[d]));
            if (frame_err[d] === 1'b1)  fe_cnt[d]++;
            if (parity_err[d] === 1'b1) pe_cnt[d]++;
            if (overrun[d] === 1'b1)    ov_cnt[d]++;
        end
        if (rx_valid[0] === 1'b1 && !prev_valid0 && rise_cyc < 0) begin
            rise_cyc     = cyc;
            busy_at_rise = busy[0];
        end
        prev_valid0 = (rx_valid[0] === 1'b1);
    endtask

    // Sends one frame to instance d: start bit, 8 data bits LSB first,
    // optional parity bit, stop bit. A bit lasts OS sample_tick pulses.
    // gl_bit/gl_tick flip the line at one tick position of one bit;
    // abort_bit/abort_tick pulse reset at that point and abandon the frame.
    task automatic applyStimulus(input int d, input logic [7:0] word, input bit use_par,
                                 input bit par_bit, input bit stop_val,
                                 input int gl_bit, input int gl_tick,
                                 input bit rand_mode, input bit ready_on_done,
                                 input int abort_bit, input int abort_tick);
        logic [9:0] bits;
        int         nbits;
        int         k;
        bit         t;
        bits  = '1;
        nbits = use_par ? 10 : 9;
        for (int i = 0; i < 8; i++) bits[i] = word[i];
        if (use_par) bits[8] = par_bit;
        bits[nbits-1] = stop_val;

        rx_in[d] = 1'b0;
        repeat (2) step();
        start_det[d] = 1'b1;
        ev_start[d]  = 1'b1;
        step();
        start_cyc    = cyc;
        start_det[d] = 1'b0;

        for (int i = 0; i < nbits; i++) begin
            k = 0;
            while (k < OS) begin
                t = rand_mode ? ($urandom_range(3) != 0) : 1'b1;
                sample_tick = t;
                rx_in[d] = (i == gl_bit && k == gl_tick) ? ~bits[i] : bits[i];
                if (rand_mode) rx_ready[d] = 1'($urandom_range(1));
                if (i == abort_bit && k == abort_tick) begin
                    rst_n = 1'b0;
                    step();
                    rst_n       = 1'b1;
                    rx_in[d]    = 1'b1;
                    sample_tick = 1'b1;
                    return;
                end
                if (i == nbits - 1 && k == OS / 2 + 1 && t) begin
                    ev_done[d] = 1'b1;
                    ev_word[d] = word;
                    ev_ferr[d] = !stop_val;
                    ev_perr[d] = use_par && (par_bit != even_parity_bit(word));
                    if (ready_on_done) rx_ready[d] = 1'b1;
                end
                if (rand_mode && i < 8 && $urandom_range(15) == 0) begin
                    start_det[d] = 1'b1;
                    ev_start[d]  = 1'b1;
                end
                step();
                start_det[d] = 1'b0;
                if (ready_on_done) rx_ready[d] = 1'b0;
                if (t) k++;
            end
        end
        rx_in[d]    = 1'b1;
        sample_tick = 1'b1;
        repeat (3) step();
    endtask

    task automatic drain(input int d);
        rx_ready[d] = 1'b1;
        step();
        rx_ready[d] = 1'b0;
        checkOutput($sformatf("drained%0d", d), 32'(rx_valid[d]), 32'd0);
    endtask

    initial begin
        int fe0, pe0, ov0;
        logic [7:0] w;
        int d;
        rst_n       = 1'b0;
        sample_tick = 1'b1;
        rx_in       = 2'b11;
        start_det   = 2'b00;
        rx_ready    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ev_start[i] = 1'b0; ev_done[i] = 1'b0; ev_ferr[i] = 1'b0; ev_perr[i] = 1'b0;
            ev_word[i] = 8'h00; m_valid[i] = 1'b0; m_data[i] = 8'h00; m_busy[i] = 1'b0;
            fe_cnt[i] = 0; pe_cnt[i] = 0; ov_cnt[i] = 0;
        end

        repeat (3) step();
        checkOutput("reset_data", 32'(rx_data[0]), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step();

        // 0xA5, tick every clk: word visible at cycle T+139 with busy low
        rise_cyc = -1;
        applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, -1, 0);
        checkOutput("latency_T139", 32'(rise_cyc - start_cyc + 1), 32'd139);
        checkOutput("busy_at_T139", 32'(busy_at_rise), 32'd0);
        checkOutput("data_A5", 32'(rx_data[0]), 32'hA5);
        drain(0);

        // Single-clk glitch at vote tick 8 of bit 3 is outvoted
        applyStimulus(0, 8'h00, 1'b0, 1'b0, 1'b1, 3, 8, 1'b0, 1'b0, -1, 0);
        checkOutput("glitch_data", 32'(rx_data[0]), 32'h00);
        checkOutput("glitch_valid", 32'(rx_valid[0]), 32'd1);
        drain(0);

        // Stop bit held low
        fe0 = fe_cnt[0];
        applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, -1, 0);
        checkOutput("frame_err_count", 32'(fe_cnt[0] - fe0), 32'd1);
        checkOutput("frame_err_valid", 32'(rx_valid[0]), 32'd0);

        // Even parity: 0x07 needs parity 1; parity 0 must be rejected
        pe0 = pe_cnt[1];
        applyStimulus(1, 8'h07, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, -1, 0);
        checkOutput("parity_err_count", 32'(pe_cnt[1] - pe0), 32'd1);
        checkOutput("parity_err_valid", 32'(rx_valid[1]), 32'd0);
        applyStimulus(1, 8'h07, 1'b1, 1'b1, 1'b1, -1, 0, 1'b0, 1'b0, -1, 0);
        checkOutput("parity_ok_data", 32'(rx_data[1]), 32'h07);
        drain(1);

        // Overrun, then replacement with ready on the completion clk
        ov0 = ov_cnt[0];
        applyStimulus(0, 8'h11, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, -1, 0);
        applyStimulus(0, 8'h22, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, -1, 0);
        checkOutput("overrun_keep_data", 32'(rx_data[0]), 32'h11);
        checkOutput("overrun_count", 32'(ov_cnt[0] - ov0), 32'd1);
        ov0 = ov_cnt[0];
        applyStimulus(0, 8'h22, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, 1'b1, -1, 0);
        checkOutput("replace_data", 32'(rx_data[0]), 32'h22);
        checkOutput("replace_valid", 32'(rx_valid[0]), 32'd1);
        checkOutput("replace_no_overrun", 32'(ov_cnt[0] - ov0), 32'd0);
        drain(0);

        // Reset during data bit 4, then a clean frame
        fe0 = fe_cnt[0]; pe0 = pe_cnt[0]; ov0 = ov_cnt[0];
        applyStimulus(0, 8'h77, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, 4, 5);
        checkOutput("abort_busy", 32'(busy[0]), 32'd0);
        checkOutput("abort_valid", 32'(rx_valid[0]), 32'd0);
        checkOutput("abort_data", 32'(rx_data[0]), 32'h00);
        repeat (4) step();
        checkOutput("abort_no_errors", 32'((fe_cnt[0] - fe0) + (pe_cnt[0] - pe0) + (ov_cnt[0] - ov0)), 32'd0);
        applyStimulus(0, 8'h5A, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, -1, 0);
        checkOutput("after_abort_data", 32'(rx_data[0]), 32'h5A);
        drain(0);

        // Randomised frames: gated ticks, random ready, glitches, bad stop
        // and parity bits, stray start_det pulses while receiving
        for (int n = 0; n < 40; n++) begin
            d = int'($urandom_range(1));
            w = 8'($urandom);
            applyStimulus(d, w, d == 1,
                          even_parity_bit(w) ^ ($urandom_range(7) == 0),
                          $urandom_range(7) != 0,
                          ($urandom_range(1) == 1) ? int'($urandom_range(d == 1 ? 9 : 8)) : -1,
                          int'($urandom_range(OS - 1)),
                          1'b1, 1'b0, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
